// File: rtl/traffic_phase_timer.sv
// ---------------------------------------------------------------------------
// traffic_phase_timer
//   Timing responder for the highway/secondary/pedestrian light controller.
//   A free-running prescaler produces a one-second Tick; SecCount counts
//   seconds since the last restart (StateChg or Reset) and saturates at
//   MAX_T. tYel flags that the amber interval has elapsed and tSec flags
//   that the green target has been reached. The green target may be
//   stretched in EXT_T steps, up to MAX_T, if Extend is high when the count
//   reaches the current target.
//
// Optional build macro: TIMER_FREEZE_EN adds the Freeze input, which halts
//   the prescaler, counter, target and state (StateChg still clears).
//
// Ports:
//   Clock     in   rising-edge clock
//   Reset     in   synchronous active-high reset
//   StateChg  in   restart request (level, sampled every cycle)
//   Extend    in   stretch request, sampled only at target-reached events
//   Freeze    in   (TIMER_FREEZE_EN only) hold the timer
//   tYel      out  SecCount >= YEL_T since restart
//   tSec      out  green target reached (held until restart)
//   Tick      out  one-cycle pulse per one-second boundary
//   SecCount  out  seconds since restart, saturating at MAX_T
//   Extended  out  at least one extension granted since restart
// ---------------------------------------------------------------------------
module traffic_phase_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int CW       = 6,
    parameter int YEL_T    = 3,
    parameter int GRN_T    = 10,
    parameter int EXT_T    = 5,
    parameter int MAX_T    = 30
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          StateChg,
    input  logic          Extend,
`ifdef TIMER_FREEZE_EN
    input  logic          Freeze,
`endif
    output logic          tYel,
    output logic          tSec,
    output logic          Tick,
    output logic [CW-1:0] SecCount,
    output logic          Extended
);

    localparam int            PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] YEL_C   = CW'(YEL_T);
    localparam logic [CW-1:0] GRN_C   = CW'(GRN_T);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_T);
    localparam logic [CW:0]   EXT_C   = (CW + 1)'(EXT_T);

    typedef enum logic [0:0] {
        COUNT = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] pre, pre_n;
    logic [CW-1:0] target, target_n;
    logic [CW-1:0] sec_n;
    logic          tick_n, yel_n, tsec_n, ext_n;
    logic          run;

    // Seconds counter increment that sticks at the ceiling instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v >= MAX_C) ? v : v + 1'b1;
    endfunction

    // Next green target after one extension, clamped to MAX_T. Computed one
    // bit wider so the sum cannot wrap before the clamp.
    function automatic logic [CW-1:0] ext_clamp(input logic [CW-1:0] t);
        logic [CW:0] s;
        s = {1'b0, t} + EXT_C;
        return (s > {1'b0, MAX_C}) ? MAX_C : s[CW-1:0];
    endfunction

`ifdef TIMER_FREEZE_EN
    assign run = ~Freeze;
`else
    assign run = 1'b1;
`endif

    always_comb begin
        pre_n    = pre;
        sec_n    = SecCount;
        target_n = target;
        state_n  = state;
        tick_n   = 1'b0;
        yel_n    = tYel;
        tsec_n   = tSec;
        ext_n    = Extended;

        if (run) begin
            if (pre == PRE_MAX) begin
                pre_n  = '0;
                tick_n = 1'b1;
                sec_n  = sat_inc(SecCount);
            end else begin
                pre_n = pre + 1'b1;
            end

            // Extend is looked at only on the edge the count lands on the
            // target; a target already at the ceiling cannot grow further.
            if (state == COUNT && tick_n && sec_n == target) begin
                if (Extend && target < MAX_C) begin
                    target_n = ext_clamp(target);
                    ext_n    = 1'b1;
                end else begin
                    tsec_n  = 1'b1;
                    state_n = DONE;
                end
            end
        end

        // Sticky: rises on the edge SecCount reaches YEL_T.
        if (sec_n >= YEL_C) begin
            yel_n = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset || StateChg) begin
            state    <= COUNT;
            pre      <= '0;
            SecCount <= '0;
            target   <= GRN_C;
            Tick     <= 1'b0;
            tYel     <= 1'b0;
            tSec     <= 1'b0;
            Extended <= 1'b0;
        end else begin
            state    <= state_n;
            pre      <= pre_n;
            SecCount <= sec_n;
            target   <= target_n;
            Tick     <= tick_n;
            tYel     <= yel_n;
            tSec     <= tsec_n;
            Extended <= ext_n;
        end
    end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_timer
//   Self-checking bench for traffic_phase_timer with TICK_DIV=4, YEL_T=3,
//   GRN_T=10, EXT_T=5, MAX_T=30. The reference model tracks the number of
//   running cycles since restart and derives seconds, tick and flags from it
//   arithmetically. Define TIMER_FREEZE_EN to exercise the Freeze input.
// ---------------------------------------------------------------------------
module tb_traffic_phase_timer;

    localparam int TICK_DIV = 4;
    localparam int CW       = 6;
    localparam int YEL_T    = 3;
    localparam int GRN_T    = 10;
    localparam int EXT_T    = 5;
    localparam int MAX_T    = 30;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          StateChg;
    logic          Extend;
`ifdef TIMER_FREEZE_EN
    logic          Freeze;
`endif
    logic          tYel;
    logic          tSec;
    logic          Tick;
    logic [CW-1:0] SecCount;
    logic          Extended;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    int m_n, m_tgt, m_sec;
    bit m_done, m_ext, m_tick, m_yel;

    traffic_phase_timer #(
        .TICK_DIV(TICK_DIV), .CW(CW), .YEL_T(YEL_T),
        .GRN_T(GRN_T), .EXT_T(EXT_T), .MAX_T(MAX_T)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .StateChg(StateChg),
        .Extend  (Extend),
`ifdef TIMER_FREEZE_EN
        .Freeze  (Freeze),
`endif
        .tYel    (tYel),
        .tSec    (tSec),
        .Tick    (Tick),
        .SecCount(SecCount),
        .Extended(Extended)
    );

    always #5 Clock = ~Clock;

    initial begin
        #10ms;
        $display("FAIL watchdog: run exceeded time limit (observed running, required finished)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the behavioural model.
    task automatic model_step(input bit rst, input bit sc, input bit ex, input bit fr);
        if (rst || sc) begin
            m_n = 0; m_tgt = GRN_T; m_sec = 0;
            m_done = 0; m_ext = 0; m_tick = 0; m_yel = 0;
        end else if (fr) begin
            m_tick = 0;
        end else begin
            m_n++;
            m_tick = (m_n % TICK_DIV) == 0;
            m_sec  = (m_n / TICK_DIV > MAX_T) ? MAX_T : m_n / TICK_DIV;
            if (m_tick && !m_done && (m_n / TICK_DIV) == m_tgt) begin
                if (ex && m_tgt < MAX_T) begin
                    m_tgt = (m_tgt + EXT_T > MAX_T) ? MAX_T : m_tgt + EXT_T;
                    m_ext = 1;
                end else begin
                    m_done = 1;
                end
            end
            m_yel = (m_sec >= YEL_T);
        end
    endtask

    // Drive inputs, take one edge, update the model, then compare all outputs.
    task automatic cyc(input bit rst, input bit sc, input bit ex, input bit fr);
        bit f;
        Reset = rst; StateChg = sc; Extend = ex;
`ifdef TIMER_FREEZE_EN
        Freeze = fr;
        f = fr;
`else
        f = 1'b0;
        if (fr) f = 1'b0;
`endif
        @(posedge Clock);
        model_step(rst, sc, ex, f);
        #1;
        chk("SecCount", 32'(SecCount), m_sec);
        chk("Tick",     32'(Tick),     32'(m_tick));
        chk("tYel",     32'(tYel),     32'(m_yel));
        chk("tSec",     32'(tSec),     32'(m_done));
        chk("Extended", 32'(Extended), 32'(m_ext));
    endtask

    int ty, ts, ticks;

    initial begin
        Reset = 1'b1; StateChg = 1'b0; Extend = 1'b0;
`ifdef TIMER_FREEZE_EN
        Freeze = 1'b0;
`endif
        // Reset state
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        chk("rst_sec",  32'(SecCount), 0);
        chk("rst_tick", 32'(Tick), 0);
        chk("rst_tyel", 32'(tYel), 0);
        chk("rst_tsec", 32'(tSec), 0);
        chk("rst_ext",  32'(Extended), 0);

        // Basic phase, Extend low, then run deep into saturation
        cyc(0, 1, 0, 0);
        ty = -1; ts = -1; ticks = 0;
        for (int k = 1; k <= 240; k++) begin
            cyc(0, 0, 0, 0);
            if (Tick) ticks++;
            if (tYel && ty < 0) ty = k;
            if (tSec && ts < 0) begin
                ts = k;
                chk("sec_at_tsec", 32'(SecCount), 10);
                chk("ext_at_tsec", 32'(Extended), 0);
            end
        end
        chk("tyel_rise", ty, 12);
        chk("tsec_rise", ts, 40);
        chk("tick_count", ticks, 60);
        chk("sat_sec", 32'(SecCount), 30);
        chk("sat_tsec", 32'(tSec), 1);

        // Extend held throughout: target climbs to the ceiling
        cyc(0, 1, 1, 0);
        ts = -1;
        for (int k = 1; k <= 130; k++) begin
            cyc(0, 0, 1, 0);
            if (tSec && ts < 0) begin
                ts = k;
                chk("ext_sec_at_tsec", 32'(SecCount), 30);
            end
        end
        chk("ext_tsec_rise", ts, 120);
        chk("ext_flag", 32'(Extended), 1);

        // Extend only at the first target event
        cyc(0, 1, 0, 0);
        ts = -1;
        for (int k = 1; k <= 80; k++) begin
            cyc(0, 0, k <= 40, 0);
            if (tSec && ts < 0) ts = k;
        end
        chk("one_ext_tsec_rise", ts, 60);
        chk("one_ext_flag", 32'(Extended), 1);

        // Restart at SecCount=7 on a Tick edge
        cyc(0, 1, 0, 0);
        for (int k = 1; k <= 31; k++) cyc(0, 0, 0, 0);
        chk("pre_restart_sec", 32'(SecCount), 7);
        cyc(0, 1, 0, 0);
        chk("restart_sec",  32'(SecCount), 0);
        chk("restart_tyel", 32'(tYel), 0);
        chk("restart_tsec", 32'(tSec), 0);
        ty = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 0, 0, 0);
            if (tYel && ty < 0) ty = k;
        end
        chk("restart_tyel_rise", ty, 12);

`ifdef TIMER_FREEZE_EN
        // Freeze for 20 cycles at SecCount=5
        cyc(0, 1, 0, 0);
        for (int k = 1; k <= 20; k++) cyc(0, 0, 0, 0);
        ticks = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 0, 0, 1);
            if (Tick) ticks++;
        end
        chk("frz_sec", 32'(SecCount), 5);
        chk("frz_ticks", ticks, 0);
        ts = -1;
        for (int k = 41; k <= 80; k++) begin
            cyc(0, 0, 0, 0);
            if (tSec && ts < 0) ts = k;
        end
        chk("frz_tsec_rise", ts, 60);
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 499) == 0,
                $urandom_range(0, 99) < 2,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
